// File: rtl/display_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : display_scan_ctrl_pkg                                        |
// | Description : Scan FSM state encodings and the digit-select to anode map.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package display_scan_ctrl_pkg;

    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_BLANK = 2'd1;
    localparam state_t c_ST_ON    = 2'd2;
    localparam state_t c_ST_OFF   = 2'd3;

    // Digit k pulls anode bit (n-1-k) low; callers truncate to their ring width.
    function automatic logic [31:0] anode_onecold(input int unsigned sel, input int unsigned n);
        return ~(32'd1 << (n - 1 - sel));
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_scan_slot_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scan_slot_timer                                              |
// | Description : Free-running slot counter with terminal-count flag and clear.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module scan_slot_timer #(
    parameter int PRESCALE = 100000,
    parameter int CNT_W    = 17
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Clear,
    output logic [CNT_W-1:0] o_Cnt,
    output logic             o_Tc
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == c_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear || w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_Cnt = r_cnt;
    assign o_Tc  = w_tc;

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : display_scan_ctrl                                            |
// | Description : 7-segment digit scan scheduler with blanking and PWM dimming.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SEL_W     = 2,
    parameter int PRESCALE  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int DUTY_W    = 4
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_Enable,
    input  logic [DUTY_W-1:0]   i_Bright,
    input  logic [N_DIGITS-1:0] i_DigitEn,
    output logic [SEL_W-1:0]    o_Sel,
    output logic [N_DIGITS-1:0] o_Anodos,
    output logic                o_SlotStart,
    output logic                o_Lit
);

    localparam int               c_CNT_W      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CNT_W-1:0] c_STEP     = c_CNT_W'((PRESCALE - BLANK_CYC) >> DUTY_W);
    localparam logic [c_CNT_W-1:0] c_BLANK    = c_CNT_W'(BLANK_CYC);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                w_slot_start;
    logic [DUTY_W-1:0]   r_bright_q;
    logic                r_en_q;
    logic [N_DIGITS-1:0] r_anodes;
    logic                r_slot_start;
    logic                r_lit;
    logic [N_DIGITS-1:0] w_onecold;
    logic [c_CNT_W-1:0]  w_cnt;
    logic                w_tc;
    logic [c_CNT_W-1:0]  w_on_end;
    logic                w_timer_clr;

    assign w_timer_clr = (r_state == c_ST_IDLE) || !i_Enable;

    scan_slot_timer #(
        .PRESCALE (PRESCALE),
        .CNT_W    (c_CNT_W)
    ) u_slot_timer (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Clear (w_timer_clr),
        .o_Cnt   (w_cnt),
        .o_Tc    (w_tc)
    );

    assign w_on_end  = c_BLANK + c_CNT_W'(r_bright_q) * c_STEP;
    assign w_onecold = N_DIGITS'(anode_onecold(32'(w_sel_nxt), N_DIGITS));

    // Leaving IDLE outranks slot end so a fresh start always begins at digit 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_slot_start = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (i_Enable) begin
                w_state_nxt  = c_ST_BLANK;
                w_sel_nxt    = '0;
                w_slot_start = 1'b1;
            end
        end else if (!i_Enable) begin
            w_state_nxt = c_ST_IDLE;
            w_sel_nxt   = '0;
        end else if (w_tc) begin
            w_state_nxt  = c_ST_BLANK;
            w_sel_nxt    = r_sel + SEL_W'(1);
            w_slot_start = 1'b1;
        end else begin
            case (r_state)
                c_ST_BLANK: begin
                    if (w_cnt == c_BLANK_LAST) begin
                        w_state_nxt = ((r_bright_q != '0) && r_en_q) ? c_ST_ON : c_ST_OFF;
                    end
                end
                c_ST_ON: begin
                    if (w_cnt == w_on_end - c_CNT_W'(1)) begin
                        w_state_nxt = c_ST_OFF;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state      <= c_ST_IDLE;
            r_sel        <= '0;
            r_bright_q   <= '0;
            r_en_q       <= 1'b0;
            r_anodes     <= '1;
            r_slot_start <= 1'b0;
            r_lit        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_slot_start <= w_slot_start;
            r_lit        <= (w_state_nxt == c_ST_ON);
            r_anodes     <= (w_state_nxt == c_ST_ON) ? w_onecold : '1;
            if (w_slot_start) begin
                r_bright_q <= i_Bright;
                r_en_q     <= i_DigitEn[w_sel_nxt];
            end
        end
    end

    assign o_Sel       = r_sel;
    assign o_Anodos    = r_anodes;
    assign o_SlotStart = r_slot_start;
    assign o_Lit       = r_lit;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_display_scan_ctrl                                         |
// | Description : Directed self-checking bench for display_scan_ctrl.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_display_scan_ctrl;

    localparam int PRESCALE  = 16;
    localparam int BLANK_CYC = 4;
    localparam int DUTY_W    = 2;
    localparam int N_DIGITS  = 4;
    localparam int SEL_W     = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic [DUTY_W-1:0]   bright = '0;
    logic [N_DIGITS-1:0] digit_en = '0;
    logic [SEL_W-1:0]    sel;
    logic [N_DIGITS-1:0] anodos;
    logic                slot_start;
    logic                lit;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .N_DIGITS  (N_DIGITS),
        .SEL_W     (SEL_W),
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC),
        .DUTY_W    (DUTY_W)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Enable    (enable),
        .i_Bright    (bright),
        .i_DigitEn   (digit_en),
        .o_Sel       (sel),
        .o_Anodos    (anodos),
        .o_SlotStart (slot_start),
        .o_Lit       (lit)
    );

    function automatic logic [3:0] pat(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0111;
            2'd1:    return 4'b1011;
            2'd2:    return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    // Never more than one anode low.
    always @(negedge clk) begin
        n_assert++;
        assert (($countones(~anodos) <= 1) === 1'b1)
        else begin
            n_fail++;
            $error("FAIL onecold anodos=%b exp at most one low", anodos);
        end
    end

    task automatic chk(input string tag, input logic [1:0] e_sel, input logic e_ss, input logic e_lit);
        logic [3:0] e_an;
        e_an = e_lit ? pat(e_sel) : 4'b1111;
        n_assert++;
        assert (sel === e_sel) else begin
            n_fail++; $error("FAIL %s sel got %0d exp %0d", tag, sel, e_sel);
        end
        n_assert++;
        assert (anodos === e_an) else begin
            n_fail++; $error("FAIL %s anodos got %b exp %b", tag, anodos, e_an);
        end
        n_assert++;
        assert (slot_start === e_ss) else begin
            n_fail++; $error("FAIL %s slot_start got %b exp %b", tag, slot_start, e_ss);
        end
        n_assert++;
        assert (lit === e_lit) else begin
            n_fail++; $error("FAIL %s lit got %b exp %b", tag, lit, e_lit);
        end
    endtask

    // Check slot cycles c0..c1 of digit s, lit for cnt lo..hi (lo>hi = dark).
    task automatic run(input string tag, input logic [1:0] s, input int c0, input int c1,
                       input int lo, input int hi);
        for (int c = c0; c <= c1; c++) begin
            chk($sformatf("%s s%0d c%0d", tag, s, c), s, (c == 0), (c >= lo && c <= hi));
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset", 2'd0, 1'b0, 1'b0);

        // Full brightness, all digits
        rst = 1'b0; enable = 1'b1; bright = 2'd3; digit_en = 4'b1111;
        @(negedge clk);
        run("t1", 2'd0, 0, 15, 4, 12);
        run("t1", 2'd1, 0, 15, 4, 12);
        run("t1", 2'd2, 0, 15, 4, 12);
        run("t1", 2'd3, 0, 15, 4, 12);
        run("t1", 2'd0, 0, 15, 4, 12);

        // Brightness 1 then 0; each takes effect at the following slot
        bright = 2'd1;
        run("t2", 2'd1, 0, 15, 4, 12);
        run("t2", 2'd2, 0, 15, 4, 6);
        run("t2", 2'd3, 0, 15, 4, 6);
        bright = 2'd0;
        run("t2", 2'd0, 0, 15, 4, 6);
        run("t2", 2'd1, 0, 15, 1, 0);
        run("t2", 2'd2, 0, 15, 1, 0);
        run("t2", 2'd3, 0, 15, 1, 0);

        // Only digits 1 and 3 enabled
        bright = 2'd3; digit_en = 4'b1010;
        run("t3", 2'd0, 0, 15, 1, 0);
        run("t3", 2'd1, 0, 15, 4, 12);
        run("t3", 2'd2, 0, 15, 1, 0);
        run("t3", 2'd3, 0, 15, 4, 12);
        run("t3", 2'd0, 0, 15, 1, 0);

        // Brightness change mid-slot
        digit_en = 4'b1111;
        run("t4", 2'd1, 0, 7, 4, 12);
        bright = 2'd1;
        run("t4", 2'd1, 8, 15, 4, 12);
        run("t4", 2'd2, 0, 15, 4, 6);

        // Disable while ON, then re-enable
        run("t5", 2'd3, 0, 5, 4, 6);
        chk("t5 s3 c6", 2'd3, 1'b0, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk("t5 idle", 2'd0, 1'b0, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        run("t5", 2'd0, 0, 15, 4, 6);
        bright = 2'd3;
        run("t5", 2'd1, 0, 15, 4, 6);

        // Reset while digit 2 is ON
        run("t6", 2'd2, 0, 5, 4, 12);
        chk("t6 s2 c6", 2'd2, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 reset", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6 reset hold", 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        run("t6", 2'd0, 0, 15, 4, 12);
        run("t6", 2'd1, 0, 3, 4, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
